// File: rtl/muldiv_sequencer.sv
// Iterative MIPS-style multiply/divide unit owning the HI/LO pair.
// Resolves one product or quotient bit per cycle and stalls EX while busy.
module muldiv_sequencer #(
    parameter int NB_DATA     = 32,
    parameter int NB_FUNCTION = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_valid,
    input  logic [NB_FUNCTION-1:0] i_funct,
    input  logic [NB_DATA-1:0]     i_rs,
    input  logic [NB_DATA-1:0]     i_rt,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [NB_DATA-1:0]     o_result,
    output logic [NB_DATA-1:0]     o_hi,
    output logic [NB_DATA-1:0]     o_lo
);

    localparam int CNT_W = $clog2(NB_DATA);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NB_DATA - 1);

    localparam logic [NB_FUNCTION-1:0] FN_MFHI  = NB_FUNCTION'(6'b010000);
    localparam logic [NB_FUNCTION-1:0] FN_MTHI  = NB_FUNCTION'(6'b010001);
    localparam logic [NB_FUNCTION-1:0] FN_MFLO  = NB_FUNCTION'(6'b010010);
    localparam logic [NB_FUNCTION-1:0] FN_MTLO  = NB_FUNCTION'(6'b010011);
    localparam logic [NB_FUNCTION-1:0] FN_MULT  = NB_FUNCTION'(6'b011000);
    localparam logic [NB_FUNCTION-1:0] FN_MULTU = NB_FUNCTION'(6'b011001);
    localparam logic [NB_FUNCTION-1:0] FN_DIV   = NB_FUNCTION'(6'b011010);
    localparam logic [NB_FUNCTION-1:0] FN_DIVU  = NB_FUNCTION'(6'b011011);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [2*NB_DATA-1:0]   acc_q, acc_d;
    logic [NB_DATA-1:0]     opB_q, opB_d;
    logic                   isDiv_q, isDiv_d;
    logic                   negLow_q, negLow_d;
    logic                   negHigh_q, negHigh_d;
    logic                   divZero_q, divZero_d;
    logic [NB_DATA-1:0]     hi_q, hi_d;
    logic [NB_DATA-1:0]     lo_q, lo_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   isMulDiv;
    logic                   isSignedOp;
    logic                   isDivOp;
    logic                   rsNeg;
    logic                   rtNeg;
    logic [NB_DATA-1:0]     rsMag;
    logic [NB_DATA-1:0]     rtMag;
    logic                   accept;

    logic [NB_DATA:0]       mulSum;
    logic [NB_DATA:0]       remShift;
    logic                   remFits;
    logic [NB_DATA-1:0]     remDiff;
    logic [NB_DATA-1:0]     quotMag;
    logic [NB_DATA-1:0]     remMag;
    logic [2*NB_DATA-1:0]   prodSigned;

    // Operand decode; signed forms work on magnitudes and reapply signs in FIX.
    always_comb begin
        isMulDiv   = (i_funct == FN_MULT) || (i_funct == FN_MULTU) ||
                     (i_funct == FN_DIV)  || (i_funct == FN_DIVU);
        isSignedOp = (i_funct == FN_MULT) || (i_funct == FN_DIV);
        isDivOp    = (i_funct == FN_DIV)  || (i_funct == FN_DIVU);
        rsNeg      = isSignedOp && i_rs[NB_DATA-1];
        rtNeg      = isSignedOp && i_rt[NB_DATA-1];
        rsMag      = rsNeg ? (~i_rs + 1'b1) : i_rs;
        rtMag      = rtNeg ? (~i_rt + 1'b1) : i_rt;
        accept     = (state_q == ST_IDLE) && i_valid && isMulDiv;
    end

    // Per-iteration arithmetic for both the shift-add and restoring paths.
    always_comb begin
        mulSum     = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} +
                     (acc_q[0] ? {1'b0, opB_q} : {(NB_DATA+1){1'b0}});
        remShift   = {acc_q[2*NB_DATA-1:NB_DATA], acc_q[NB_DATA-1]};
        remFits    = (remShift >= {1'b0, opB_q});
        remDiff    = NB_DATA'(remShift - {1'b0, opB_q});
        quotMag    = acc_q[NB_DATA-1:0];
        remMag     = acc_q[2*NB_DATA-1:NB_DATA];
        prodSigned = negLow_q ? (~acc_q + 1'b1) : acc_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            opB_q     <= '0;
            isDiv_q   <= 1'b0;
            negLow_q  <= 1'b0;
            negHigh_q <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opB_q     <= opB_d;
            isDiv_q   <= isDiv_d;
            negLow_q  <= negLow_d;
            negHigh_q <= negHigh_d;
            divZero_q <= divZero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = isDivOp ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL, ST_DIV: begin
                if (count_q == LAST_COUNT) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered status; busy/done are precomputed from state_d.
    always_comb begin
        count_d   = count_q;
        acc_d     = acc_q;
        opB_d     = opB_q;
        isDiv_d   = isDiv_q;
        negLow_d  = negLow_q;
        negHigh_d = negHigh_q;
        divZero_d = divZero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_FIX);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    count_d   = '0;
                    isDiv_d   = isDivOp;
                    negLow_d  = rsNeg ^ rtNeg;
                    negHigh_d = rsNeg;
                    divZero_d = (i_rt == '0);
                    if (isDivOp) begin
                        acc_d = {{NB_DATA{1'b0}}, rsMag};
                        opB_d = rtMag;
                    end else begin
                        acc_d = {{NB_DATA{1'b0}}, rtMag};
                        opB_d = rsMag;
                    end
                end else if (i_valid && (i_funct == FN_MTHI)) begin
                    hi_d = i_rs;
                end else if (i_valid && (i_funct == FN_MTLO)) begin
                    lo_d = i_rs;
                end
            end
            ST_MUL: begin
                acc_d   = {mulSum, acc_q[NB_DATA-1:1]};
                count_d = count_q + 1'b1;
            end
            ST_DIV: begin
                if (remFits) begin
                    acc_d = {remDiff, acc_q[NB_DATA-2:0], 1'b1};
                end else begin
                    acc_d = {remShift[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b0};
                end
                count_d = count_q + 1'b1;
            end
            ST_FIX: begin
                if (isDiv_q) begin
                    // A zero divisor leaves the dividend as remainder; only LO is forced.
                    lo_d = divZero_q ? {NB_DATA{1'b1}} :
                           (negLow_q ? (~quotMag + 1'b1) : quotMag);
                    hi_d = negHigh_q ? (~remMag + 1'b1) : remMag;
                end else begin
                    hi_d = prodSigned[2*NB_DATA-1:NB_DATA];
                    lo_d = prodSigned[NB_DATA-1:0];
                end
            end
            default: begin
                count_d = '0;
            end
        endcase
    end

    always_comb begin
        o_result = '0;
        if (i_funct == FN_MFHI) begin
            o_result = hi_q;
        end else if (i_funct == FN_MFLO) begin
            o_result = lo_q;
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule
